nfc_atom_timed_idle: RTL
========================

# nfc_atom_timed_idle

Parametrised, sequenced idle atom for the NAND flash controller PHY-facing datapath. On a start handshake it latches a target way, a cycle count and an option word. It then drives the PHY bus with a defined idle pattern for exactly that many system clocks, and signals completion with a last-step pulse. It sits alongside the other command atoms behind the atom mux and provides programmable tWHR/tRHW/tCCS-style gaps without the issuing FSM counting cycles itself.

## Interface
- NumberOfWays, 4, number of NAND ways; one CE bit per way per half-phase.
- CounterWidth, 16, width of the cycle-count input and internal counter.
- iSystemClock  in  1  system clock; all logic rising-edge.
- iReset  in  1  synchronous, active-high reset.
- iStart  in  1  start request; accepted only when oReady=1 or oLastStep=1.
- iTargetWay  in  NumberOfWays  one-hot way select; latched on accept.
- iNumOfCycles  in  CounterWidth  hold length in clocks; 0 is treated as 1; latched on accept.
- iOption  in  2  bit0 KeepCE (1: CE asserted during hold), bit1 REPreamble (1: RE pattern 4'b0011, 0: 4'b1111); latched on accept.
- oReady  out  1  high when no operation is active.
- oLastStep  out  1  one-cycle pulse on the final hold cycle.
- oDQSOutEnable  out  1  DQS output enable.
- oDQOutEnable  out  1  DQ output enable.
- oDQStrobe  out  8  DQS phase data.
- oDQ  out  32  DQ phase data.
- oChipEnable  out  2*NumberOfWays  CE enables, {way, way}.
- oReadEnable  out  4  RE phase pattern.
- oWriteEnable  out  4  WE phase pattern.
- oAddressLatchEnable  out  4  ALE phase pattern.
- oCommandLatchEnable  out  4  CLE phase pattern.

## Operation
- States: IDLE and HOLD. The counter is CounterWidth bits and counts down.
- IDLE: oReady=1. If iStart=1, latch inputs, load the counter with max(iNumOfCycles,1), and go to HOLD.
- HOLD: the counter decrements each clock. oLastStep=1 while the counter equals 1. In that cycle:
  - iStart=1: re-latch inputs, reload the counter, stay in HOLD (back-to-back).
  - iStart=0: go to IDLE.
- iStart in HOLD with counter > 1 is ignored, and the latched values do not change.
- Outputs in HOLD:
  - oDQSOutEnable=1, oDQOutEnable=1.
  - oDQStrobe=8'h00, oDQ=32'h0.
  - oWriteEnable=4'b0000, oAddressLatchEnable=4'h0, oCommandLatchEnable=4'h0.
  - oReadEnable=4'b0011 if REPreamble, else 4'b1111.
  - oChipEnable={way,way} if KeepCE, else all zero.
- Outputs in IDLE: both OutEnables=0, oChipEnable=0, oReadEnable=4'b1111, all other outputs 0.
- Multi-hot or zero iTargetWay is passed through unchanged; no checking.

## Timing
- All outputs are registered and decoded from the current state and latched registers; none is combinational from inputs.
- Reset values: oReady=1, oLastStep=0, oDQSOutEnable=0, oDQOutEnable=0, oChipEnable=0, oReadEnable=4'b1111, all other outputs 0. State is IDLE and the counter is 0.
- iStart sampled at edge E0 gives the HOLD pattern in clocks 1..N after E0. oLastStep is high in clock N, and oReady returns high in clock N+1.
- For N=1 (or 0), HOLD lasts one clock, and oReady and oLastStep toggle in the same cycle.
- Back-to-back: the second operation's first hold clock immediately follows the first operation's last clock, with no idle gap and the new pattern applied at once.
- iReset=1 in any state forces reset values at the next edge and aborts any operation in progress; iStart is ignored while iReset=1.
- Counter wrap: with iNumOfCycles=2^CounterWidth-1, the counter never underflows, and hold lasts exactly that many clocks.

## Test plan
- Reset then idle: hold iReset for 3 clocks and release. oReady=1, oReadEnable=4'b1111, oChipEnable=0, both OutEnables=0.
- Basic hold: iStart, iTargetWay=4'b0100, iNumOfCycles=5, iOption=2'b01. Exactly 5 clocks with oChipEnable=8'b0100_0100 and oReadEnable=4'b1111; oLastStep in clock 5; oReady high in clock 6.
- Zero and one count: iNumOfCycles=0 and then 1 each give a 1-clock hold, with oLastStep and oReady=0 in the same single cycle.
- Back-to-back with option change: first op (N=3, option 2'b01), then iStart during oLastStep with N=2, option 2'b10. 5 contiguous hold clocks; clocks 4-5 have oChipEnable=0 and oReadEnable=4'b0011.
- Ignored start: iStart pulsed mid-hold (counter=3) with a different way. No effect on the pattern or the length.
- Reset mid-operation: iReset asserted at hold clock 2 of N=10. Reset values at the next edge; a new iStart then runs normally.

Source files
------------

// File: rtl/nfc_atom_timed_idle.sv
// rtl/nfc_atom_timed_idle.sv - timed idle atom: drives a fixed PHY idle pattern for a programmed number of clocks
module nfc_atom_timed_idle #(
    parameter int NumberOfWays = 4,
    parameter int CounterWidth = 16
) (
    input  logic                      iSystemClock,
    input  logic                      iReset,
    input  logic                      iStart,
    input  logic [NumberOfWays-1:0]   iTargetWay,
    input  logic [CounterWidth-1:0]   iNumOfCycles,
    input  logic [1:0]                iOption,
    output logic                      oReady,
    output logic                      oLastStep,
    output logic                      oDQSOutEnable,
    output logic                      oDQOutEnable,
    output logic [7:0]                oDQStrobe,
    output logic [31:0]               oDQ,
    output logic [2*NumberOfWays-1:0] oChipEnable,
    output logic [3:0]                oReadEnable,
    output logic [3:0]                oWriteEnable,
    output logic [3:0]                oAddressLatchEnable,
    output logic [3:0]                oCommandLatchEnable
);

    typedef enum logic {
        sIdle = 1'b0,
        sHold = 1'b1
    } state_t;

    localparam logic [CounterWidth-1:0] CountOne = CounterWidth'(1);

    state_t                  state;
    state_t                  nextState;
    logic [CounterWidth-1:0] counter;
    logic [CounterWidth-1:0] nextCounter;
    logic [NumberOfWays-1:0] targetWay;
    logic [NumberOfWays-1:0] nextTargetWay;
    logic [1:0]              option;
    logic [1:0]              nextOption;
    logic                    loadOp;
    logic                    nextHold;

    // A start is taken in IDLE or on the final hold clock (back-to-back chaining).
    always_comb begin
        nextState     = state;
        nextCounter   = counter;
        nextTargetWay = targetWay;
        nextOption    = option;
        loadOp        = 1'b0;
        case (state)
            sIdle: begin
                if (iStart) begin
                    loadOp = 1'b1;
                end
            end
            sHold: begin
                if (counter == CountOne) begin
                    if (iStart) begin
                        loadOp = 1'b1;
                    end else begin
                        nextState   = sIdle;
                        nextCounter = '0;
                    end
                end else begin
                    nextCounter = counter - CountOne;
                end
            end
            default: begin
                nextState   = sIdle;
                nextCounter = '0;
            end
        endcase
        if (loadOp) begin
            nextState     = sHold;
            nextCounter   = (iNumOfCycles == '0) ? CountOne : iNumOfCycles;
            nextTargetWay = iTargetWay;
            nextOption    = iOption;
        end
    end

    assign nextHold = (nextState == sHold);

    // Outputs are registered from the next-state values so the pattern lines up with the state.
    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state               <= sIdle;
            counter             <= '0;
            targetWay           <= '0;
            option              <= '0;
            oReady              <= 1'b1;
            oLastStep           <= 1'b0;
            oDQSOutEnable       <= 1'b0;
            oDQOutEnable        <= 1'b0;
            oDQStrobe           <= 8'h00;
            oDQ                 <= 32'h0;
            oChipEnable         <= '0;
            oReadEnable         <= 4'b1111;
            oWriteEnable        <= 4'b0000;
            oAddressLatchEnable <= 4'h0;
            oCommandLatchEnable <= 4'h0;
        end else begin
            state               <= nextState;
            counter             <= nextCounter;
            targetWay           <= nextTargetWay;
            option              <= nextOption;
            oReady              <= !nextHold;
            oLastStep           <= nextHold && (nextCounter == CountOne);
            oDQSOutEnable       <= nextHold;
            oDQOutEnable        <= nextHold;
            oDQStrobe           <= 8'h00;
            oDQ                 <= 32'h0;
            oChipEnable         <= (nextHold && nextOption[0]) ? {nextTargetWay, nextTargetWay} : '0;
            oReadEnable         <= (nextHold && nextOption[1]) ? 4'b0011 : 4'b1111;
            oWriteEnable        <= 4'b0000;
            oAddressLatchEnable <= 4'h0;
            oCommandLatchEnable <= 4'h0;
        end
    end

endmodule
